// File: rtl/ip_pkg.sv
// Shared IPv4 receive-path definitions: result codes, protocol constants,
// decoder state encoding and the ones'-complement add used by the checksum.
package ip_pkg;

  // Frame result codes reported with IP_DONE
  typedef enum logic [1:0] {
    IP_TYPE_UNSUP = 2'b00,
    IP_TYPE_UDP   = 2'b01,
    IP_TYPE_CSUM  = 2'b10,
    IP_TYPE_TRUNC = 2'b11
  } ip_type_e;

  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [3:0]  IPV4_MIN_IHL   = 4'd5;
  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  // Index of the last byte of the fixed 20-byte header
  localparam logic [5:0]  IPV4_BASE_LAST = 6'd19;

  // Gray-coded decoder states, matching the rest of the RX path
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_HDR  = 3'b001,
    ST_OPT  = 3'b011,
    ST_PAY  = 3'b010,
    ST_DROP = 3'b110,
    ST_DONE = 3'b111
  } ip_state_e;

  // 16-bit ones'-complement add with end-around carry folded back in.
  // The folded result cannot carry again (max 0xFFFE + 1).
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones'-complement 16-bit word accumulator with synchronous clear.
// 'sum' is the running total including the word presented this cycle,
// so a caller can test the complete sum on the cycle of its last word.
module ip_csum_acc
  import ip_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        add_en,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;

  // Running total and next accumulator value; clear wins over add
  always_comb begin
    sum   = add_en ? csum_add(sum_q, word) : sum_q;
    sum_d = clr ? 16'h0000 : sum;
  end

  // Accumulator register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sum_q <= 16'h0000;
    else     sum_q <= sum_d;
  end

endmodule

// File: rtl/ipv4_decoder.sv
// Byte-serial IPv4 header decoder. Parses and validates the header, then
// forwards the UDP datagram (trimmed to total_length) one cycle delayed,
// and reports a result code with a one-cycle IP_DONE per frame.
module ipv4_decoder
  import ip_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8_00C7
) (
  input  logic        RST,
  input  logic        CLK,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_DATA_VLD,
  input  logic        IP_EN,
  output logic [7:0]  PAYLOAD_DATA,
  output logic        PAYLOAD_VLD,
  output logic        UDP_EN,
  output logic [31:0] SRC_IP,
  output logic [15:0] PAYLOAD_LEN,
  output logic        IP_DONE,
  output logic [1:0]  IP_TYPE
);

  ip_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;        // index of the header byte being sampled
  logic [3:0]  ver_q, ver_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  hi_q, hi_d;          // high byte of the current checksum word
  logic [15:0] tlen_q, tlen_d;
  logic [13:0] frag_q, frag_d;      // {MF, DF-less reserved, offset} low 14 bits
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  ip_type_e    result_q, result_d;  // verdict taken on the last header byte
  logic [15:0] rem_q, rem_d;        // payload bytes still to forward
  logic        first_q, first_d;    // next forwarded byte is the first one
  logic [7:0]  pdata_q, pdata_d;
  logic        pvld_q, pvld_d;
  logic        udp_en_q, udp_en_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] plen_q, plen_d;
  logic        done_q, done_d;
  ip_type_e    ip_type_q, ip_type_d;

  logic        in_hdr;
  logic        hdr_start;
  logic        hdr_active;
  logic [5:0]  idx;
  logic [5:0]  last_idx;
  logic        is_last;
  logic [15:0] hdr_len;
  logic [15:0] pay_len;
  logic [31:0] dst_now;
  logic [15:0] csum_word;
  logic [15:0] csum_sum;
  logic        csum_clr;
  logic        csum_add_en;
  logic        ok_ver, ok_len, ok_frag, ok_proto, ok_dst, ok_csum;
  ip_type_e    verdict;

  // Byte position decode and header-length arithmetic
  always_comb begin
    in_hdr     = (state_q == ST_HDR) || (state_q == ST_OPT);
    hdr_start  = (state_q == ST_IDLE) && IP_EN && IN_DATA_VLD;
    hdr_active = hdr_start || (in_hdr && IN_DATA_VLD);
    // Byte 0 is sampled while still in IDLE, on the IP_EN edge
    idx        = in_hdr ? cnt_q : 6'd0;
    // A bad IHL (< 5) still walks the full fixed header before rejecting
    last_idx   = (ihl_q > IPV4_MIN_IHL) ? ({ihl_q, 2'b00} - 6'd1) : IPV4_BASE_LAST;
    is_last    = in_hdr && (cnt_q == last_idx);
    hdr_len    = {10'd0, ihl_q, 2'b00};
    pay_len    = tlen_q - hdr_len;
    // With IHL = 5 the last destination byte is also the last header byte
    dst_now    = (idx == IPV4_BASE_LAST) ? {dst_q[23:0], IN_DATA} : dst_q;
  end

  assign csum_clr    = (state_q == ST_IDLE);
  assign csum_add_en = hdr_active && idx[0];
  assign csum_word   = {hi_q, IN_DATA};

  ip_csum_acc u_csum (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (csum_clr),
    .add_en (csum_add_en),
    .word   (csum_word),
    .sum    (csum_sum)
  );

  // Header checks and result priority: checksum error beats unsupported
  always_comb begin
    ok_ver   = (ver_q == IPV4_VERSION) && (ihl_q >= IPV4_MIN_IHL);
    ok_len   = tlen_q >= (hdr_len + 16'd8);
    ok_frag  = !frag_q[13] && (frag_q[12:0] == 13'd0);
    ok_proto = (proto_q == IP_PROTO_UDP);
    ok_dst   = (dst_now == LOCAL_IP);
    ok_csum  = (csum_sum == 16'hFFFF);
    verdict  = IP_TYPE_UDP;
    if (!ok_csum)
      verdict = IP_TYPE_CSUM;
    else if (!(ok_ver && ok_len && ok_frag && ok_proto && ok_dst))
      verdict = IP_TYPE_UNSUP;
  end

  // Field capture, next state and output strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ver_d     = ver_q;
    ihl_d     = ihl_q;
    hi_d      = hi_q;
    tlen_d    = tlen_q;
    frag_d    = frag_q;
    proto_d   = proto_q;
    src_d     = src_q;
    dst_d     = dst_q;
    result_d  = result_q;
    rem_d     = rem_q;
    first_d   = first_q;
    pdata_d   = IN_DATA;
    pvld_d    = 1'b0;
    udp_en_d  = 1'b0;
    src_ip_d  = src_ip_q;
    plen_d    = plen_q;
    done_d    = 1'b0;
    ip_type_d = ip_type_q;

    if (hdr_active) begin
      if (!idx[0]) hi_d = IN_DATA;
      case (idx)
        6'd0:  begin ver_d = IN_DATA[7:4]; ihl_d = IN_DATA[3:0]; end
        6'd2:  tlen_d[15:8] = IN_DATA;
        6'd3:  tlen_d[7:0]  = IN_DATA;
        6'd6:  frag_d[13:8] = IN_DATA[5:0];
        6'd7:  frag_d[7:0]  = IN_DATA;
        6'd9:  proto_d      = IN_DATA;
        6'd12, 6'd13, 6'd14, 6'd15: src_d = {src_q[23:0], IN_DATA};
        6'd16, 6'd17, 6'd18, 6'd19: dst_d = {dst_q[23:0], IN_DATA};
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (hdr_start) begin
          state_d = ST_HDR;
          cnt_d   = 6'd1;
        end
      end
      ST_HDR, ST_OPT: begin
        if (!IN_DATA_VLD) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          ip_type_d = IP_TYPE_TRUNC;
        end else if (is_last) begin
          state_d  = (verdict == IP_TYPE_UDP) ? ST_PAY : ST_DROP;
          result_d = verdict;
          src_ip_d = src_q;
          plen_d   = pay_len;
          rem_d    = pay_len;
          first_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == IPV4_BASE_LAST) state_d = ST_OPT;
        end
      end
      ST_PAY: begin
        if (!IN_DATA_VLD) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          ip_type_d = (rem_q != 16'd0) ? IP_TYPE_TRUNC : IP_TYPE_UDP;
        end else if (rem_q != 16'd0) begin
          // Bytes beyond total_length are Ethernet padding and are dropped
          pvld_d   = 1'b1;
          udp_en_d = first_q;
          first_d  = 1'b0;
          rem_d    = rem_q - 16'd1;
        end
      end
      ST_DROP: begin
        if (!IN_DATA_VLD) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          ip_type_d = result_q;
        end
      end
      ST_DONE: begin
        // IP_EN seen here is deliberately ignored
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      ver_q     <= 4'd0;
      ihl_q     <= 4'd0;
      hi_q      <= 8'd0;
      tlen_q    <= 16'd0;
      frag_q    <= 14'd0;
      proto_q   <= 8'd0;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      result_q  <= IP_TYPE_UNSUP;
      rem_q     <= 16'd0;
      first_q   <= 1'b0;
      pdata_q   <= 8'd0;
      pvld_q    <= 1'b0;
      udp_en_q  <= 1'b0;
      src_ip_q  <= 32'd0;
      plen_q    <= 16'd0;
      done_q    <= 1'b0;
      ip_type_q <= IP_TYPE_UNSUP;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ver_q     <= ver_d;
      ihl_q     <= ihl_d;
      hi_q      <= hi_d;
      tlen_q    <= tlen_d;
      frag_q    <= frag_d;
      proto_q   <= proto_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      pdata_q   <= pdata_d;
      pvld_q    <= pvld_d;
      udp_en_q  <= udp_en_d;
      src_ip_q  <= src_ip_d;
      plen_q    <= plen_d;
      done_q    <= done_d;
      ip_type_q <= ip_type_d;
    end
  end

  assign PAYLOAD_DATA = pdata_q;
  assign PAYLOAD_VLD  = pvld_q;
  assign UDP_EN       = udp_en_q;
  assign SRC_IP       = src_ip_q;
  assign PAYLOAD_LEN  = plen_q;
  assign IP_DONE      = done_q;
  assign IP_TYPE      = ip_type_q;

endmodule

// File: tb/tb_ipv4_decoder.sv
// Scoreboard bench for ipv4_decoder: stimulus pushes expected frame results
// and payload bytes; a negedge monitor pops and compares on DUT outputs.
module tb_ipv4_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  IN_DATA = 8'd0;
  logic        IN_DATA_VLD = 1'b0;
  logic        IP_EN = 1'b0;
  logic [7:0]  PAYLOAD_DATA;
  logic        PAYLOAD_VLD;
  logic        UDP_EN;
  logic [31:0] SRC_IP;
  logic [15:0] PAYLOAD_LEN;
  logic        IP_DONE;
  logic [1:0]  IP_TYPE;

  ipv4_decoder #(.LOCAL_IP(32'hC0A8_00C7)) dut (
    .RST          (RST),
    .CLK          (CLK),
    .IN_DATA      (IN_DATA),
    .IN_DATA_VLD  (IN_DATA_VLD),
    .IP_EN        (IP_EN),
    .PAYLOAD_DATA (PAYLOAD_DATA),
    .PAYLOAD_VLD  (PAYLOAD_VLD),
    .UDP_EN       (UDP_EN),
    .SRC_IP       (SRC_IP),
    .PAYLOAD_LEN  (PAYLOAD_LEN),
    .IP_DONE      (IP_DONE),
    .IP_TYPE      (IP_TYPE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  typ;
    int          nvld;
    int          nudp;
    logic [31:0] src;
    logic [15:0] len;
    bit          meta;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  byte_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          discard = 1'b0;
  logic [7:0]  hdr [0:23];
  int          frame_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s frame=%0d actual=%0h required=%0h", name, frame_no, act, req);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int k);
    logic [31:0] v;
    v = k * 7 + 3;
    return v[7:0];
  endfunction

  task automatic load_base();
    logic [159:0] base;
    base = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
    for (int i = 0; i < 20; i++) hdr[i] = base[159 - 8*i -: 8];
    for (int i = 20; i < 24; i++) hdr[i] = 8'h00;
  endtask

  // Rewrites the checksum field so the header of n bytes is valid
  task automatic fix_csum(input int n);
    logic [16:0] s;
    logic [15:0] acc;
    acc = 16'h0000;
    hdr[10] = 8'h00;
    hdr[11] = 8'h00;
    for (int i = 0; i < n; i += 2) begin
      s   = {1'b0, acc} + {1'b0, hdr[i], hdr[i+1]};
      acc = s[15:0] + {15'd0, s[16]};
    end
    {hdr[10], hdr[11]} = ~acc;
  endtask

  task automatic push_exp(input logic [1:0] typ, input int nvld, input int nudp,
                          input logic [31:0] src, input logic [15:0] len, input bit meta);
    exp_t e;
    e.typ = typ; e.nvld = nvld; e.nudp = nudp; e.src = src; e.len = len; e.meta = meta;
    exp_q.push_back(e);
    for (int k = 0; k < nvld; k++) byte_q.push_back(pay_byte(k));
  endtask

  // Sends nsend bytes (header then payload), optional stray IP_EN at byte
  // ipen_at, and optionally pokes IP_EN+VLD in the DONE cycle.
  task automatic send(input int nhdr, input int nsend, input int ipen_at, input bit poke);
    frame_no++;
    for (int i = 0; i < nsend; i++) begin
      @(negedge CLK);
      IN_DATA_VLD = 1'b1;
      IP_EN       = (i == 0) || (i == ipen_at);
      IN_DATA     = (i < nhdr) ? hdr[i] : pay_byte(i - nhdr);
    end
    @(negedge CLK);
    IN_DATA_VLD = 1'b0; IP_EN = 1'b0; IN_DATA = 8'h00;
    if (poke) begin
      @(negedge CLK);
      IN_DATA_VLD = 1'b1; IP_EN = 1'b1; IN_DATA = 8'h45;
      @(negedge CLK);
      IN_DATA_VLD = 1'b0; IP_EN = 1'b0; IN_DATA = 8'h00;
    end
    repeat (4) @(negedge CLK);
  endtask

  // Monitor: payload byte compare and per-frame result compare
  int   mon_nvld = 0;
  int   mon_nudp = 0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (RST) begin
      mon_nvld = 0;
      mon_nudp = 0;
    end else begin
      if (UDP_EN) begin
        mon_nudp++;
        check("udp_en_with_vld", {31'd0, PAYLOAD_VLD}, 32'd1);
      end
      if (PAYLOAD_VLD && !discard) begin
        mon_nvld++;
        if (byte_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_payload frame=%0d actual=%0h required=none", frame_no, PAYLOAD_DATA);
        end else begin
          check("payload_byte", {24'd0, PAYLOAD_DATA}, {24'd0, byte_q.pop_front()});
        end
      end
      if (IP_DONE) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ip_done frame=%0d actual=type%0h required=none", frame_no, IP_TYPE);
        end else begin
          mon_e = exp_q.pop_front();
          check("ip_type", {30'd0, IP_TYPE}, {30'd0, mon_e.typ});
          check("payload_count", mon_nvld, mon_e.nvld);
          check("udp_en_count", mon_nudp, mon_e.nudp);
          if (mon_e.meta) begin
            check("src_ip", SRC_IP, mon_e.src);
            check("payload_len", {16'd0, PAYLOAD_LEN}, {16'd0, mon_e.len});
          end
          $display("frame %0d done type=%0h vld=%0d udp_en=%0d src=%08h len=%0d",
                   frame_no, IP_TYPE, mon_nvld, mon_nudp, SRC_IP, PAYLOAD_LEN);
        end
        mon_nvld = 0;
        mon_nudp = 0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_payload_data"}, {24'd0, PAYLOAD_DATA}, 32'd0);
    check({tag, "_payload_vld"}, {31'd0, PAYLOAD_VLD}, 32'd0);
    check({tag, "_udp_en"}, {31'd0, UDP_EN}, 32'd0);
    check({tag, "_src_ip"}, SRC_IP, 32'd0);
    check({tag, "_payload_len"}, {16'd0, PAYLOAD_LEN}, 32'd0);
    check({tag, "_ip_done"}, {31'd0, IP_DONE}, 32'd0);
    check({tag, "_ip_type"}, {30'd0, IP_TYPE}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: valid UDP, 95 payload bytes
    load_base();
    push_exp(2'b01, 95, 1, 32'hC0A8_0001, 16'd95, 1'b1);
    send(20, 115, -1, 1'b0);

    // 2: corrupted checksum
    load_base(); hdr[11] = 8'h62;
    push_exp(2'b10, 0, 0, 32'h0, 16'h0, 1'b0);
    send(20, 115, -1, 1'b0);

    // 3: TCP protocol
    load_base(); hdr[9] = 8'h06; fix_csum(20);
    push_exp(2'b00, 0, 0, 32'h0, 16'h0, 1'b0);
    send(20, 115, -1, 1'b0);

    // 4: foreign destination
    load_base(); hdr[19] = 8'hC8; fix_csum(20);
    push_exp(2'b00, 0, 0, 32'h0, 16'h0, 1'b0);
    send(20, 115, -1, 1'b0);

    // 5: more-fragments set
    load_base(); hdr[6] = 8'h20; fix_csum(20);
    push_exp(2'b00, 0, 0, 32'h0, 16'h0, 1'b0);
    send(20, 115, -1, 1'b0);

    // 6: IHL 6 with one option word; stray IP_EN mid-frame and in DONE
    load_base(); hdr[0] = 8'h46; hdr[2] = 8'h00; hdr[3] = 8'h77;
    hdr[20] = 8'h01; hdr[21] = 8'h01; hdr[22] = 8'h01; hdr[23] = 8'h00;
    fix_csum(24);
    push_exp(2'b01, 95, 1, 32'hC0A8_0001, 16'd95, 1'b1);
    send(24, 119, 30, 1'b1);

    // 7: 28-byte datagram plus 18 bytes of Ethernet padding
    load_base(); hdr[3] = 8'h1C; fix_csum(20);
    push_exp(2'b01, 8, 1, 32'hC0A8_0001, 16'd8, 1'b1);
    send(20, 46, -1, 1'b0);

    // 8: stream ends after header byte 10
    load_base();
    push_exp(2'b11, 0, 0, 32'h0, 16'h0, 1'b0);
    send(20, 11, -1, 1'b0);

    // 9: stream ends after 40 of 95 payload bytes
    load_base(); hdr[15] = 8'h09; fix_csum(20);
    push_exp(2'b11, 40, 1, 32'hC0A8_0009, 16'd95, 1'b1);
    send(20, 60, -1, 1'b0);

    // 10: reset in the middle of the payload
    load_base();
    frame_no++;
    discard = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      IN_DATA_VLD = 1'b1;
      IP_EN       = (i == 0);
      IN_DATA     = (i < 20) ? hdr[i] : pay_byte(i - 20);
    end
    @(posedge CLK);
    #2;
    check("pre_reset_payload_vld", {31'd0, PAYLOAD_VLD}, 32'd1);
    RST = 1'b1;
    #1;
    check_outputs_zero("midreset");
    @(negedge CLK);
    IN_DATA_VLD = 1'b0; IP_EN = 1'b0; IN_DATA = 8'h00;
    @(negedge CLK);
    RST = 1'b0;
    discard = 1'b0;
    repeat (3) @(negedge CLK);

    // 11: normal frame after reset
    load_base(); hdr[15] = 8'h05; fix_csum(20);
    push_exp(2'b01, 95, 1, 32'hC0A8_0005, 16'd95, 1'b1);
    send(20, 115, -1, 1'b0);

    // Drain with a bounded wait
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    check("leftover_payload", byte_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
